arb_req_queue: RTL and testbench

Two-channel request queue that sits directly upstream of the 2-requester arbiter (`request[1:0]` / `grant[1:0]`). Each channel buffers up to DEPTH pending transactions in its own FIFO, raises its request line while it holds data, and pops and emits its head transaction when the arbiter grants it. The output is a single merged, registered transaction stream tagged with the winning channel id.

---
 rtl/arb_req_queue.sv | 125 ++++++++++++
 tb/tb_arb_req_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/arb_req_queue.sv
// Two-channel request queue feeding a 2-requester arbiter: per-channel FIFOs raise
// request while non-empty, pop on grant, and merge into one registered output stream.

module arb_req_queue_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push_vld,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_ready,
  output logic              o_nempty,
  output logic [DATA_W-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;

  // No bypass: a full FIFO refuses a push even if it pops in the same cycle.
  assign o_ready  = !rst && (r_count < L_FULL);
  assign o_nempty = (r_count != '0);
  assign o_head   = r_mem[r_rd_ptr];
  assign w_push   = i_push_vld && o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

module arb_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic [1:0]        request,
  input  logic [1:0]        grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              err
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]             w_in_vld, w_ready, w_nempty, w_pop;
  logic [NUM_CH-1:0][DATA_W-1:0] w_in_data, w_head;
  logic                          w_illegal;
  logic                          r_out_valid, r_out_id, r_err;
  logic [DATA_W-1:0]             r_out_data;

  assign w_in_vld  = {in1_valid, in0_valid};
  assign w_in_data = {in1_data, in0_data};

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      arb_req_queue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push_vld  (w_in_vld[g]),
        .i_push_data (w_in_data[g]),
        .i_pop       (w_pop[g]),
        .o_ready     (w_ready[g]),
        .o_nempty    (w_nempty[g]),
        .o_head      (w_head[g])
      );
    end
  endgenerate

  // Stale grants (no request) are dropped; a double grant serves channel 0 first.
  assign w_pop[0]  = grant[0] && w_nempty[0];
  assign w_pop[1]  = grant[1] && w_nempty[1] && !w_pop[0];
  assign w_illegal = (grant == 2'b11) && (|w_nempty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= |w_pop;
      if (|w_pop) begin
        r_out_data <= w_pop[0] ? w_head[0] : w_head[1];
        r_out_id   <= !w_pop[0];
      end
      if (w_illegal) r_err <= 1'b1;
    end
  end

  assign in0_ready = w_ready[0];
  assign in1_ready = w_ready[1];
  assign request   = w_nempty;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign err       = r_err;
endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: reset, single transfer, fill/full, wrapping
// stream, stale grant, double grant and reset while a transfer is in flight.

module tb_arb_req_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in0_valid = 1'b0, in1_valid = 1'b0;
  logic [7:0] in0_data = '0, in1_data = '0;
  logic       in0_ready, in1_ready;
  logic [1:0] request;
  logic [1:0] grant = 2'b00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_id;
  logic       err;

  int n_pass = 0;
  int n_chk  = 0;

  arb_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .request   (request),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held 0-12 ns
    #2;
    chk("rst_request", 32'(request), 32'h0);
    chk("rst_ready", 32'({in1_ready, in0_ready}), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    #10 rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'({in1_ready, in0_ready}), 32'h3);
    chk("post_rst_request", 32'(request), 32'h0);

    // Single push then one-edge grant
    in0_valid = 1'b1; in0_data = 8'hA5;
    tick();
    in0_valid = 1'b0;
    chk("single_request", 32'(request), 32'h1);
    chk("single_no_out", 32'(out_valid), 32'h0);
    grant = 2'b01;
    tick();
    grant = 2'b00;
    chk("single_out_valid", 32'(out_valid), 32'h1);
    chk("single_out_data", 32'(out_data), 32'hA5);
    chk("single_out_id", 32'(out_id), 32'h0);
    chk("single_request_drop", 32'(request), 32'h0);
    tick();
    chk("single_pulse_end", 32'(out_valid), 32'h0);
    chk("single_data_hold", 32'(out_data), 32'hA5);

    // Fill channel 1, fifth push refused, then drain in order
    for (int i = 1; i <= 4; i++) begin
      in1_valid = 1'b1; in1_data = 8'(i);
      tick();
    end
    chk("full_ready", 32'(in1_ready), 32'h0);
    chk("full_request", 32'(request), 32'h2);
    in1_data = 8'h05;
    tick();
    in1_valid = 1'b0;
    chk("full_still_refused", 32'(in1_ready), 32'h0);
    grant = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("drain_valid", 32'(out_valid), 32'h1);
      chk("drain_data", 32'(out_data), 32'(k));
      chk("drain_id", 32'(out_id), 32'h1);
    end
    grant = 2'b00;
    chk("drain_request", 32'(request), 32'h0);
    chk("drain_ready", 32'(in1_ready), 32'h1);
    tick();
    chk("drain_no_fifth", 32'(out_valid), 32'h0);

    // Streaming push/pop on channel 0 with grant held; ends with a stale-grant edge
    grant = 2'b01;
    for (int t = 0; t <= 11; t++) begin
      in0_valid = (t < 10);
      in0_data  = 8'(t);
      tick();
      if (t == 0 || t == 11) begin
        chk("stream_no_out", 32'(out_valid), 32'h0);
      end else begin
        chk("stream_valid", 32'(out_valid), 32'h1);
        chk("stream_data", 32'(out_data), 32'(t - 1));
        chk("stream_id", 32'(out_id), 32'h0);
      end
      chk("stream_request", 32'(request), (t <= 9) ? 32'h1 : 32'h0);
      chk("stream_ready", 32'(in0_ready), 32'h1);
    end
    in0_valid = 1'b0;
    chk("stale_err", 32'(err), 32'h0);
    grant = 2'b00;

    // Double grant with both channels pending
    in0_valid = 1'b1; in0_data = 8'h11;
    in1_valid = 1'b1; in1_data = 8'h22;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk("dbl_request", 32'(request), 32'h3);
    grant = 2'b11;
    tick();
    grant = 2'b00;
    chk("dbl_valid", 32'(out_valid), 32'h1);
    chk("dbl_data", 32'(out_data), 32'h11);
    chk("dbl_id", 32'(out_id), 32'h0);
    chk("dbl_request_after", 32'(request), 32'h2);
    chk("dbl_err", 32'(err), 32'h1);
    tick();
    chk("dbl_err_sticky", 32'(err), 32'h1);
    grant = 2'b10;
    tick();
    grant = 2'b00;
    chk("dbl_ch1_data", 32'(out_data), 32'h22);
    chk("dbl_ch1_id", 32'(out_id), 32'h1);
    chk("dbl_ch1_request", 32'(request), 32'h0);
    chk("dbl_err_held", 32'(err), 32'h1);

    // Reset while a transfer is in flight and data is queued
    in0_valid = 1'b1; in0_data = 8'h33;
    in1_valid = 1'b1; in1_data = 8'h44;
    tick();
    in1_valid = 1'b0;
    in0_data = 8'h34;
    grant = 2'b01;
    tick();
    in0_valid = 1'b0;
    grant = 2'b00;
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    chk("pre_rst_data", 32'(out_data), 32'h33);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    chk("midrst_request", 32'(request), 32'h0);
    chk("midrst_ready", 32'({in1_ready, in0_ready}), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_ready", 32'({in1_ready, in0_ready}), 32'h3);
    chk("after_rst_request", 32'(request), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
